// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl_pkg
// Brief    : Shared definitions for the MEM-stage data-memory initiator:
//            load/store op encodings, controller states, lane constants.
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_ctrl_pkg;

  // Load/store operation encoding carried on req_op
  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } mem_op_e;

  // Controller states
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RD        = 3'd1,
    S_WR_SETUP  = 3'd2,
    S_WR_STROBE = 3'd3,
    S_WR_HOLD   = 3'd4,
    S_DONE      = 3'd5
  } state_e;

  // Big-endian lane numbering: lane 0 is the most significant byte
  localparam int unsigned C_BYTE_W   = 8;
  localparam int unsigned C_WORD_W   = 32;
  localparam logic [1:0]  C_LANE_MSB = 2'd0;
  localparam logic [1:0]  C_LANE_LSB = 2'd3;

  // Loads are every op that is not a store
  function automatic logic is_load(input mem_op_e op);
    return (op != OP_SW) && (op != OP_SH) && (op != OP_SB);
  endfunction

  // Words need lane 0; halfwords need an even lane; bytes are always aligned
  function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] lane);
    logic r;
    r = 1'b0;
    case (op)
      OP_LW, OP_SW:         r = (lane != 2'b00);
      OP_LH, OP_LHU, OP_SH: r = lane[0];
      default:              r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_load_extract.sv
`default_nettype none
// ============================================================================
// Module   : load_extract
// Brief    : Selects the addressed byte/halfword lane of a memory word
//            (big-endian) and sign- or zero-extends it to 32 bits.
// Revision : 1.0 - initial release
// ============================================================================
module load_extract
  import mem_access_ctrl_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select followed by extension chosen by the op
  always_comb begin
    w_byte = word[7:0];
    case (lane)
      C_LANE_MSB: w_byte = word[31:24];
      2'd1:       w_byte = word[23:16];
      2'd2:       w_byte = word[15:8];
      C_LANE_LSB: w_byte = word[7:0];
      default:    w_byte = word[7:0];
    endcase
    w_half = lane[1] ? word[15:0] : word[31:16];

    data = word;
    case (op)
      OP_LH:   data = {{16{w_half[15]}}, w_half};
      OP_LHU:  data = {16'h0000, w_half};
      OP_LB:   data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  data = {24'h000000, w_byte};
      default: data = word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Brief    : MEM-stage initiator for the word-organised data memory. Takes one
//            load/store per handshake, performs read-modify-write for sub-word
//            stores, returns extended load data with its rd tag, and stalls
//            upstream while busy.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int AW     = 7,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        stall,
  output logic        misalign_err
);

  localparam int         CW        = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] C_RD_LAST = CW'(RD_LAT - 1);

  state_e          r_state, w_state_next;
  mem_op_e         r_op;
  logic [AW+1:0]   r_addr;
  logic [31:0]     r_wdata;
  logic [4:0]      r_rd;
  logic            r_err;
  logic [CW-1:0]   r_rd_cnt;
  logic [31:0]     r_wb_data;
  logic [4:0]      r_wb_rd;

  mem_op_e         w_req_op;
  logic            w_accept;
  logic            w_rd_last;
  logic [31:0]     w_load_data;
  logic [31:0]     w_merged;
  logic            w_unused_addr;

  assign w_req_op  = mem_op_e'(req_op);
  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign w_rd_last = (r_rd_cnt == C_RD_LAST);

  // High address bits beyond the memory size wrap and are deliberately dropped
  assign w_unused_addr = &{1'b0, req_addr[31:AW+2]};

  assign mem_address    = {{(32-AW){1'b0}}, r_addr[AW+1:2]};
  assign mem_write_data = r_wdata;
  assign wb_data        = r_wb_data;
  assign wb_rd          = r_wb_rd;

  load_extract u_load_extract (
    .op   (r_op),
    .lane (r_addr[1:0]),
    .word (mem_read_data),
    .data (w_load_data)
  );

  // Insert the new store data into the addressed lane of the word just read
  always_comb begin
    w_merged = mem_read_data;
    if (r_op == OP_SH) begin
      if (r_addr[1]) w_merged[15:0]  = r_wdata[15:0];
      else           w_merged[31:16] = r_wdata[15:0];
    end else begin
      case (r_addr[1:0])
        2'd0:    w_merged[31:24] = r_wdata[7:0];
        2'd1:    w_merged[23:16] = r_wdata[7:0];
        2'd2:    w_merged[15:8]  = r_wdata[7:0];
        default: w_merged[7:0]   = r_wdata[7:0];
      endcase
    end
  end

  // State register; reset aborts any access immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and strobe decode; strobes come straight from state so a
  // reset removes mem_write without waiting for a clock
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    stall        = 1'b1;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    wb_valid     = 1'b0;
    misalign_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        stall     = 1'b0;
        if (w_accept) begin
          if (is_misaligned(w_req_op, req_addr[1:0])) w_state_next = S_DONE;
          else if (w_req_op == OP_SW)                 w_state_next = S_WR_SETUP;
          else                                        w_state_next = S_RD;
        end
      end
      S_RD: begin
        mem_read = 1'b1;
        if (w_rd_last) w_state_next = is_load(r_op) ? S_DONE : S_WR_SETUP;
      end
      S_WR_SETUP:  w_state_next = S_WR_STROBE;
      S_WR_STROBE: begin
        mem_write    = 1'b1;
        w_state_next = S_WR_HOLD;
      end
      S_WR_HOLD:   w_state_next = S_DONE;
      S_DONE: begin
        // A dropped misaligned request reports an error instead of completing
        wb_valid     = !r_err;
        misalign_err = r_err;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Request capture, read-latency count, store merge and write-back registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= OP_LW;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rd      <= '0;
      r_err     <= 1'b0;
      r_rd_cnt  <= '0;
      r_wb_data <= '0;
      r_wb_rd   <= '0;
    end else begin
      if (w_accept) begin
        r_op     <= w_req_op;
        r_addr   <= req_addr[AW+1:0];
        r_wdata  <= req_wdata;
        r_rd     <= req_rd;
        r_err    <= is_misaligned(w_req_op, req_addr[1:0]);
        r_rd_cnt <= '0;
      end
      if (r_state == S_RD) begin
        if (!w_rd_last) begin
          r_rd_cnt <= r_rd_cnt + 1'b1;
        end else if (is_load(r_op)) begin
          r_wb_data <= w_load_data;
          r_wb_rd   <= r_rd;
        end else begin
          r_wdata <= w_merged;
        end
      end
      if (r_state == S_WR_HOLD) begin
        r_wb_data <= '0;
        r_wb_rd   <= '0;
      end
    end
  end

endmodule
`default_nettype wire
